corepwm_tb_ctrl: RTL

//  Sequencer for the CorePWM timebase counter. Holds the active period/prescale values that feed the

---
 rtl/corepwm_pkg.sv | 14 +
 rtl/corepwm_tb_shadow.sv | 54 +++++
 rtl/corepwm_tb_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/corepwm_pkg.sv
// Shared types and reset defaults for the CorePWM timebase sequencer.
package corepwm_pkg;

   typedef enum logic [1:0] {
      TB_IDLE = 2'd0,
      TB_ARM  = 2'd1,
      TB_RUN  = 2'd2,
      TB_STOP = 2'd3
   } tb_state_t;

   localparam logic [7:0] PERIOD_RST_DEF   = 8'hFF;
   localparam logic [7:0] PRESCALE_RST_DEF = 8'h00;

endpackage

// File: rtl/corepwm_tb_shadow.sv
// Active period/prescale registers with a one-deep shadow that commits on a period boundary.
module corepwm_tb_shadow
   import corepwm_pkg::*;
#(
   parameter int                    APB_DWIDTH   = 8,
   parameter logic [APB_DWIDTH-1:0] PERIOD_RST   = PERIOD_RST_DEF,
   parameter logic [APB_DWIDTH-1:0] PRESCALE_RST = PRESCALE_RST_DEF
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic [APB_DWIDTH-1:0] cfg_period,
   input  logic [APB_DWIDTH-1:0] cfg_prescale,
   input  logic                  cfg_wr,
   input  logic                  direct,
   input  logic                  boundary,
   output logic [APB_DWIDTH-1:0] period_reg,
   output logic [APB_DWIDTH-1:0] prescale_reg,
   output logic                  upd_pend,
   output logic                  upd_done
);

   logic [APB_DWIDTH-1:0] shadow_period;
   logic [APB_DWIDTH-1:0] shadow_prescale;

   // A write landing on the boundary (or while idle) supersedes any shadow content.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         shadow_period   <= '0;
         shadow_prescale <= '0;
         period_reg      <= PERIOD_RST;
         prescale_reg    <= PRESCALE_RST;
         upd_pend        <= 1'b0;
         upd_done        <= 1'b0;
      end else begin
         upd_done <= 1'b0;
         if (cfg_wr && (direct || boundary)) begin
            period_reg   <= cfg_period;
            prescale_reg <= cfg_prescale;
            upd_pend     <= 1'b0;
            upd_done     <= 1'b1;
         end else if (boundary && upd_pend) begin
            period_reg   <= shadow_period;
            prescale_reg <= shadow_prescale;
            upd_pend     <= 1'b0;
            upd_done     <= 1'b1;
         end else if (cfg_wr) begin
            shadow_period   <= cfg_period;
            shadow_prescale <= cfg_prescale;
            upd_pend        <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/corepwm_tb_ctrl.sv
// Timebase sequencer: buffered period/prescale updates and period-aligned PWM enable with burst.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   TB_IDLE | outputs off, config writes go straight to active regs
//   TB_ARM  | enable requested, waiting for the next period start
//   TB_RUN  | outputs on, optional burst countdown per boundary
//   TB_STOP | stop requested, outputs on until the period ends
module corepwm_tb_ctrl
   import corepwm_pkg::*;
#(
   parameter int                    APB_DWIDTH   = 8,
   parameter logic [APB_DWIDTH-1:0] PERIOD_RST   = PERIOD_RST_DEF,
   parameter logic [APB_DWIDTH-1:0] PRESCALE_RST = PRESCALE_RST_DEF,
   parameter int                    BURST_W      = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic [APB_DWIDTH-1:0] cfg_period,
   input  logic [APB_DWIDTH-1:0] cfg_prescale,
   input  logic                  cfg_wr,
   input  logic                  ctrl_en,
   input  logic [BURST_W-1:0]    burst_len,
   input  logic [APB_DWIDTH-1:0] period_cnt,
   input  logic                  sync_pulse,
   output logic [APB_DWIDTH-1:0] period_reg,
   output logic [APB_DWIDTH-1:0] prescale_reg,
   output logic                  pwm_en,
   output logic                  upd_pend,
   output logic                  upd_done,
   output logic                  period_end
);

   tb_state_t            state;
   logic [BURST_W-1:0]   burst_cnt;
   logic                 boundary;

   // Same condition the timebase uses to wrap period_cnt back to zero.
   assign boundary = sync_pulse && (period_cnt >= period_reg);

   corepwm_tb_shadow #(
      .APB_DWIDTH   (APB_DWIDTH),
      .PERIOD_RST   (PERIOD_RST),
      .PRESCALE_RST (PRESCALE_RST)
   ) u_shadow (
      .PCLK         (PCLK),
      .PRESETN      (PRESETN),
      .cfg_period   (cfg_period),
      .cfg_prescale (cfg_prescale),
      .cfg_wr       (cfg_wr),
      .direct       (state == TB_IDLE),
      .boundary     (boundary),
      .period_reg   (period_reg),
      .prescale_reg (prescale_reg),
      .upd_pend     (upd_pend),
      .upd_done     (upd_done)
   );

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state      <= TB_IDLE;
         burst_cnt  <= '0;
         pwm_en     <= 1'b0;
         period_end <= 1'b0;
      end else begin
         period_end <= boundary;
         case (state)
            TB_IDLE: begin
               pwm_en <= 1'b0;
               if (ctrl_en) begin
                  state     <= TB_ARM;
                  burst_cnt <= burst_len;
               end
            end
            TB_ARM: begin
               if (!ctrl_en) begin
                  state <= TB_IDLE;
               end else if (boundary) begin
                  state  <= TB_RUN;
                  pwm_en <= 1'b1;
               end
            end
            TB_RUN: begin
               if (boundary && (burst_cnt != '0))
                  burst_cnt <= burst_cnt - BURST_W'(1);
               // Burst exhaustion wins over a concurrent stop request.
               if (boundary && (burst_cnt == BURST_W'(1))) begin
                  state  <= TB_IDLE;
                  pwm_en <= 1'b0;
               end else if (!ctrl_en) begin
                  state <= TB_STOP;
               end
            end
            TB_STOP: begin
               if (ctrl_en) begin
                  state <= TB_RUN;
               end else if (boundary) begin
                  state  <= TB_IDLE;
                  pwm_en <= 1'b0;
               end
            end
            default: begin
               state  <= TB_IDLE;
               pwm_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
